// File: rtl/sub16_serial_if.sv
// Operand/result handshake bundle for the digit-serial subtractor.
interface sub16_serial_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    // Producer/consumer side: presents operands and takes results.
    modport master (
        output in_valid, a, b, b_in, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow
    );

    // Subtractor side.
    modport slave (
        input  in_valid, a, b, b_in, out_ready,
        output in_ready, out_valid, diff, borrow, overflow
    );
endinterface

// File: rtl/sub16_serial.sv
// Digit-serial subtractor: a - b - b_in, DIGIT bits per cycle from the LSB up,
// with valid/ready handshakes on the operand and result sides.
module sub16_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    sub16_serial_if.slave    bus
);
    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT:0]         dsub;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_shift;

    // One digit of the subtraction; operands shift down so the live digit is
    // always the low one, and results shift into the accumulator from the top.
    always_comb begin
        dsub      = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                    - {{DIGIT{1'b0}}, brw_q};
        acc_cat   = {dsub[DIGIT-1:0], acc_q};
        acc_shift = acc_cat[WIDTH+DIGIT-1:DIGIT];
    end

    // Next-state and datapath update for IDLE / CALC / DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        brw_d       = brw_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.b_in;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                acc_d = acc_shift;
                brw_d = dsub[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    // Last digit holds the MSBs: overflow when operand signs
                    // differ and the result sign departs from the minuend's.
                    cnt_d       = '0;
                    diff_d      = acc_shift;
                    borrow_d    = dsub[DIGIT];
                    ovf_d       = (a_q[DIGIT-1] != b_q[DIGIT-1]) &&
                                  (dsub[DIGIT-1] != a_q[DIGIT-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, operand, accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            brw_q       <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            brw_q       <= brw_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // in_ready is masked by rst so it is low in reset and high on the first
    // cycle after release without waiting for an edge.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_sub16_serial.sv
// Directed and random checks of sub16_serial against an arithmetic model.
module tb_sub16_serial;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    sub16_serial_if #(.WIDTH(16)) bus ();

    sub16_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         output logic [15:0] d, output logic br, output logic ov);
        int ua, ub, sa, sb, s;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        s  = sa - sb - int'(bi);
        d  = 16'((ua - ub - int'(bi)) & 32'hFFFF);
        br = (ua < ub + int'(bi));
        ov = (s < -32768) || (s > 32767);
    endtask

    // Present one operand set, wait (bounded) for the result, compare it.
    // Leaves the block in DONE with out_valid high.
    task automatic start_and_wait(input string tag, input logic [15:0] a,
                                  input logic [15:0] b, input logic bi,
                                  input logic [15:0] ed, input logic eb, input logic eo);
        int lat;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a = a; bus.b = b; bus.b_in = bi; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.b_in = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd4);
        check({tag, ".diff"}, 32'(bus.diff), 32'(ed));
        check({tag, ".borrow"}, 32'(bus.borrow), 32'(eb));
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(eo));
    endtask

    task automatic consume(input string tag, input logic [15:0] held);
        bus.out_ready = 1'b1;
        tick();
        check({tag, ".ov_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(bus.in_ready), 32'd1);
        check({tag, ".held"}, 32'(bus.diff), 32'(held));
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] d;
        logic        br;
        logic        ov;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        logic [15:0] md;
        logic        mb, mo;
        logic [15:0] ra, rb;
        logic        rbi;
        logic [15:0] held;

        n_total = 0;
        n_pass  = 0;
        vecs[0] = '{16'h158A, 16'h7095, 1'b0, 16'hA4F5, 1'b1, 1'b0};
        vecs[1] = '{16'h52AF, 16'h9A4E, 1'b1, 16'hB860, 1'b1, 1'b1};
        vecs[2] = '{16'hB903, 16'hC6BD, 1'b0, 16'hF246, 1'b1, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst.in_ready", 32'(bus.in_ready), 32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.diff", 32'(bus.diff), 32'd0);
        check("rst.borrow", 32'(bus.borrow), 32'd0);
        check("rst.overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        #1;
        check("rel.in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        // Directed vectors; out_ready already high so out_valid lasts one cycle.
        foreach (vecs[i]) begin
            start_and_wait($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bi,
                           vecs[i].d, vecs[i].br, vecs[i].ov);
            tick();
            check($sformatf("vec%0d.one_cycle", i), 32'(bus.out_valid), 32'd0);
            check($sformatf("vec%0d.idle", i), 32'(bus.in_ready), 32'd1);
        end

        // Random operands against the model.
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rbi = 1'($urandom);
            if (i == 0) begin ra = 16'h7FFF; rb = 16'h8000; rbi = 1'b0; end
            model(ra, rb, rbi, md, mb, mo);
            start_and_wait($sformatf("rnd%0d", i), ra, rb, rbi, md, mb, mo);
            consume($sformatf("rnd%0d", i), md);
            if (($urandom % 3) == 0) tick();
        end

        // Back-pressure: hold the result while stray operands are offered.
        bus.out_ready = 1'b0;
        ra = 16'h1234; rb = 16'h4321; rbi = 1'b1;
        model(ra, rb, rbi, md, mb, mo);
        start_and_wait("bp", ra, rb, rbi, md, mb, mo);
        held = md;
        for (int i = 0; i < 10; i++) begin
            bus.a = 16'($urandom); bus.b = 16'($urandom); bus.b_in = 1'($urandom);
            bus.in_valid = 1'($urandom);
            tick();
            check($sformatf("bp%0d.out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("bp%0d.diff", i), 32'(bus.diff), 32'(md));
            check($sformatf("bp%0d.borrow", i), 32'(bus.borrow), 32'(mb));
            check($sformatf("bp%0d.overflow", i), 32'(bus.overflow), 32'(mo));
        end
        bus.in_valid = 1'b0;
        consume("bp", held);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("bp_after%0d.out_valid", i), 32'(bus.out_valid), 32'd0);
        end

        // Reset during the second CALC cycle aborts the operation.
        bus.out_ready = 1'b1;
        bus.a = 16'h9999; bus.b = 16'h1111; bus.b_in = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("abort.diff", 32'(bus.diff), 32'd0);
        check("abort.out_valid", 32'(bus.out_valid), 32'd0);
        check("abort.in_ready", 32'(bus.in_ready), 32'd0);
        check("abort.borrow", 32'(bus.borrow), 32'd0);
        check("abort.overflow", 32'(bus.overflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("abort%0d.no_valid", i), 32'(bus.out_valid), 32'd0);
        end
        start_and_wait("post_abort", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
        consume("post_abort", 16'h0002);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
